// File: rtl/peripheral_bridge_apb2ahb_pkg.sv
// ----------------------------------------------------------------------------
// peripheral_bridge_apb2ahb_pkg
// Shared types and AHB encodings for the APB4-slave to AHB3-Lite-master
// bridge. No ports. Imported by peripheral_bridge_strb2size and
// peripheral_bridge_apb2ahb_master.
// Optional feature macro used by the top: PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
// ----------------------------------------------------------------------------
package peripheral_bridge_apb2ahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Non-cacheable, non-bufferable, privileged data access.
  localparam logic [3:0] HPROT_RESET = 4'b0011;

endpackage

// File: rtl/peripheral_bridge_strb2size.sv
// ----------------------------------------------------------------------------
// peripheral_bridge_strb2size
// Combinational decode of APB write strobes into AHB transfer size and the
// low two address bits. Reads are always word accesses.
// Ports:
//   pstrb_i    [3:0]  APB write strobes
//   pwrite_i          APB direction (1 = write)
//   hsize_o    [2:0]  AHB HSIZE encoding
//   lo_o       [1:0]  low byte-address bits for HADDR
//   illegal_o         strobe pattern has no single-transfer AHB equivalent
// ----------------------------------------------------------------------------
module peripheral_bridge_strb2size
  import peripheral_bridge_apb2ahb_pkg::*;
(
  input  logic [3:0] pstrb_i,
  input  logic       pwrite_i,
  output logic [2:0] hsize_o,
  output logic [1:0] lo_o,
  output logic       illegal_o
);

  always_comb begin
    hsize_o   = HSIZE_WORD;
    lo_o      = 2'b00;
    illegal_o = 1'b0;
    if (pwrite_i) begin
      unique case (pstrb_i)
        4'b1111: begin hsize_o = HSIZE_WORD; lo_o = 2'b00; end
        4'b0011: begin hsize_o = HSIZE_HALF; lo_o = 2'b00; end
        4'b1100: begin hsize_o = HSIZE_HALF; lo_o = 2'b10; end
        4'b0001: begin hsize_o = HSIZE_BYTE; lo_o = 2'b00; end
        4'b0010: begin hsize_o = HSIZE_BYTE; lo_o = 2'b01; end
        4'b0100: begin hsize_o = HSIZE_BYTE; lo_o = 2'b10; end
        4'b1000: begin hsize_o = HSIZE_BYTE; lo_o = 2'b11; end
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_bridge_apb2ahb_master.sv
// ----------------------------------------------------------------------------
// peripheral_bridge_apb2ahb_master
// Same-clock APB4 slave to AHB3-Lite master. Every APB access becomes one
// AHB SINGLE/NONSEQ transfer; PREADY is raised only after the AHB data phase
// has ended. One transfer outstanding, no buffering.
//
// Optional feature macro: PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
//   adds err_clr_i, err_valid_o, err_addr_o (sticky record of the last
//   HADDR that completed with PSLVERR=1).
//
// Ports:
//   HCLK, HRESET                  clock, synchronous active-high reset
//   PSEL PENABLE PWRITE PADDR
//   PWDATA PSTRB PPROT            APB request
//   PRDATA PREADY PSLVERR         APB completion
//   HADDR HWDATA HWRITE HSIZE
//   HBURST HPROT HTRANS HMASTLOCK AHB master request
//   HRDATA HREADY HRESP           AHB response
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for APB access phase; request fields latched on trigger
// ADDR  | NONSEQ on the bus, held until HREADY
// DATA  | AHB data phase; waits for HREADY, tracks two-cycle ERROR
// DONE  | PREADY for one cycle with PSLVERR / PRDATA
// ----------------------------------------------------------------------------
module peripheral_bridge_apb2ahb_master
  import peripheral_bridge_apb2ahb_pkg::*;
#(
  parameter int                    HADDR_SIZE = 32,
  parameter int                    HDATA_SIZE = 32,
  parameter int                    PADDR_SIZE = 16,
  parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,

  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic [HDATA_SIZE-1:0] PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  output logic [HDATA_SIZE-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,

  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic                  HRESP
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
  ,
  input  logic                  err_clr_i,
  output logic                  err_valid_o,
  output logic [HADDR_SIZE-1:0] err_addr_o
`endif
);

  state_e state_q, state_d;

  logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
  logic [HDATA_SIZE-1:0] hwdata_q;
  logic [HDATA_SIZE-1:0] rdata_q;
  logic                  hwrite_q;
  logic [2:0]            hsize_q;
  logic [3:0]            hprot_q, hprot_d;
  logic                  err_q;

  logic                  trigger;
  logic [2:0]            dec_hsize;
  logic [1:0]            dec_lo;
  logic                  dec_illegal;
  logic [HADDR_SIZE-1:0] paddr_ext;
  logic                  unused_ok;

  // Byte-address bits of PADDR are replaced by the strobe-derived offset,
  // PPROT[1] (secure) has no AHB3-Lite counterpart.
  assign unused_ok = ^{PADDR[1:0], PPROT[1]};

  assign trigger = PSEL & PENABLE;

  peripheral_bridge_strb2size u_strb2size (
    .pstrb_i   (PSTRB),
    .pwrite_i  (PWRITE),
    .hsize_o   (dec_hsize),
    .lo_o      (dec_lo),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    paddr_ext                   = '0;
    paddr_ext[PADDR_SIZE-1:0]   = {PADDR[PADDR_SIZE-1:2], dec_lo};
    haddr_d                     = HADDR_BASE | paddr_ext;
    hprot_d                     = {1'b0, 1'b0, PPROT[0], ~PPROT[2]};
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    HTRANS  = HTRANS_IDLE;
    PREADY  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) state_d = dec_illegal ? ST_DONE : ST_ADDR;
      end
      ST_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        if (HREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        // HREADY low with ERROR is the first half of the two-cycle error
        // response; it is treated as a plain wait.
        if (HREADY) state_d = ST_DONE;
      end
      ST_DONE: begin
        PREADY  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request / response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_WORD;
      hprot_q  <= HPROT_RESET;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && trigger) begin
        haddr_q  <= haddr_d;
        hwdata_q <= PWDATA;
        hwrite_q <= PWRITE;
        hsize_q  <= dec_hsize;
        hprot_q  <= hprot_d;
        err_q    <= dec_illegal;
        rdata_q  <= '0;
      end
      if (state_q == ST_DATA && HREADY) begin
        err_q <= (HRESP == HRESP_ERROR);
        if (HRESP == HRESP_OKAY && !hwrite_q) rdata_q <= HRDATA;
        else                                  rdata_q <= '0;
      end
    end
  end

  assign HADDR     = haddr_q;
  assign HWDATA    = hwdata_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HPROT     = hprot_q;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;

  // Completion fields are only meaningful while PREADY is high.
  assign PSLVERR = (state_q == ST_DONE) & err_q;
  assign PRDATA  = (state_q == ST_DONE) ? rdata_q : '0;

`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
  logic                  err_valid_q;
  logic [HADDR_SIZE-1:0] err_addr_q;

  // A new error completion takes priority over a clear in the same cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (state_q == ST_DONE && err_q) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= haddr_q;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
`endif

endmodule

// File: tb/tb_peripheral_bridge_apb2ahb_master.sv
module tb_peripheral_bridge_apb2ahb_master;

  localparam int          HA    = 32;
  localparam int          PA    = 16;
  localparam logic [31:0] HBASE = 32'h0000_0000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK, HREADY, HRESP;
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
  logic        err_clr_i;
  logic        err_valid_o;
  logic [31:0] err_addr_o;
  logic        exp_err_valid;
  logic [31:0] exp_err_addr;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  peripheral_bridge_apb2ahb_master #(
    .HADDR_SIZE(HA), .HDATA_SIZE(32), .PADDR_SIZE(PA), .HADDR_BASE(HBASE)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
    , .err_clr_i(err_clr_i), .err_valid_o(err_valid_o), .err_addr_o(err_addr_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode of write strobes, expressed through bit counting.
  function automatic void model_decode(input logic wr, input logic [3:0] strb,
                                       output logic [2:0] sz, output logic [1:0] lo,
                                       output logic bad);
    sz = 3'd2; lo = 2'd0; bad = 1'b0;
    if (!wr) return;
    if (strb == 4'hF) begin
      sz = 3'd2;
    end else if ($countones(strb) == 1) begin
      sz = 3'd0;
      for (int i = 0; i < 4; i++) if (strb[i]) lo = 2'(i);
    end else if (strb == 4'h3) begin
      sz = 3'd1; lo = 2'd0;
    end else if (strb == 4'hC) begin
      sz = 3'd1; lo = 2'd2;
    end else begin
      bad = 1'b1;
    end
  endfunction

  // One complete APB access with a scripted AHB slave. waits = data-phase
  // HREADY=0 cycles before the response; slv_err selects a two-cycle ERROR.
  task automatic apb_access(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [2:0] prot,
                            input int waits, input logic slv_err, input logic [31:0] rd);
    logic [2:0]  sz;
    logic [1:0]  lo;
    logic        bad;
    logic [31:0] exp_haddr;
    logic [3:0]  exp_hprot;
    int          done_c;
    model_decode(wr, strb, sz, lo, bad);
    exp_haddr = HBASE | ((32'(addr) & ~32'h3) + 32'(lo));
    exp_hprot = 4'((prot[0] ? 2 : 0) + (prot[2] ? 0 : 1));
    done_c    = bad ? 1 : 3 + waits + (slv_err ? 1 : 0);

    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    PSTRB = strb; PPROT = prot; HREADY = 1'b1; HRESP = 1'b0;
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
    err_clr_i = ($urandom_range(0, 3) == 0);
    if (err_clr_i) exp_err_valid = 1'b0;
`endif
    @(negedge HCLK);
    PENABLE = 1'b1;
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
    err_clr_i = 1'b0;
`endif
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge HCLK);
      check("pready", PREADY, (c == done_c) ? 1 : 0);
      check("htrans", HTRANS, (!bad && c == 1) ? 2'b10 : 2'b00);
      if (!bad && c == 1) begin
        check("haddr", HADDR, exp_haddr);
        check("hsize", HSIZE, sz);
        check("hwrite", HWRITE, wr);
        check("hprot", HPROT, exp_hprot);
        check("hburst", HBURST, 0);
        check("hmastlock", HMASTLOCK, 0);
      end
      if (!bad && wr && c >= 2 && c < done_c) check("hwdata", HWDATA, wd);
      if (c == done_c) begin
        check("pslverr", PSLVERR, (bad || slv_err) ? 1 : 0);
        check("prdata", PRDATA, (!wr && !slv_err) ? rd : 32'h0);
      end
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
      if (c == done_c + 1) begin
        if (bad || slv_err) begin exp_err_valid = 1'b1; exp_err_addr = exp_haddr; end
        check("err_valid", err_valid_o, exp_err_valid);
        if (exp_err_valid) check("err_addr", err_addr_o, exp_err_addr);
      end
`endif
      HRDATA = $urandom; HREADY = 1'b1; HRESP = 1'b0;
      if (!bad && c >= 2) begin
        int d;
        d = c - 2;
        if (d < waits) HREADY = 1'b0;
        else if (slv_err) begin
          if (d == waits) begin HREADY = 1'b0; HRESP = 1'b1; end
          else if (d == waits + 1) HRESP = 1'b1;
        end else if (d == waits) HRDATA = rd;
      end
      if (c == done_c + 1) begin PSEL = 1'b0; PENABLE = 1'b0; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] legal_strb [7];
    logic [3:0] s;
    logic       w;
    legal_strb = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    HRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    PSTRB = 0; PPROT = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
    err_clr_i = 0; exp_err_valid = 0; exp_err_addr = 0;
`endif
    repeat (2) @(negedge HCLK);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_hwrite", HWRITE, 0);
    check("rst_haddr", HADDR, 0);
    check("rst_hsize", HSIZE, 3'b010);
    check("rst_hprot", HPROT, 4'b0011);
    check("rst_hwdata", HWDATA, 0);
    check("rst_pready", PREADY, 0);
    check("rst_pslverr", PSLVERR, 0);
    check("rst_prdata", PRDATA, 0);
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
    check("rst_err_valid", err_valid_o, 0);
    check("rst_err_addr", err_addr_o, 0);
`endif
    HRESET = 1'b0;

    // Directed cases
    apb_access(1'b0, 16'h0040, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'hDEADBEEF);
    apb_access(1'b1, 16'h0013, 32'h5A00_0000, 4'b1000, 3'b001, 0, 1'b0, 32'h0);
    apb_access(1'b1, 16'h0024, 32'h1234_5678, 4'b0110, 3'b000, 0, 1'b0, 32'h0);
    apb_access(1'b0, 16'h0100, 32'h0, 4'hF, 3'b100, 3, 1'b0, 32'hCAFE_F00D);
    apb_access(1'b0, 16'h0208, 32'h0, 4'hF, 3'b000, 0, 1'b1, 32'h1111_2222);
    apb_access(1'b1, 16'h0302, 32'hAAAA_5555, 4'b1100, 3'b101, 1, 1'b0, 32'h0);

    // Reset while the data phase is stalled
    @(negedge HCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 16'h0080; PSTRB = 4'hF; PPROT = 0;
    @(negedge HCLK);
    PENABLE = 1;
    @(negedge HCLK);
    check("rr_htrans_addr", HTRANS, 2'b10);
    HREADY = 1;
    @(negedge HCLK);
    HREADY = 0; HRESET = 1;
    @(negedge HCLK);
    check("rr_htrans", HTRANS, 2'b00);
    check("rr_pready", PREADY, 0);
    check("rr_haddr", HADDR, 0);
    HRESET = 0; HREADY = 1; PSEL = 0; PENABLE = 0;
`ifdef PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN
    exp_err_valid = 0;
`endif
    apb_access(1'b0, 16'h0084, 32'h0, 4'hF, 3'b010, 0, 1'b0, 32'h0BAD_C0DE);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) s = 4'($urandom);
      else                           s = legal_strb[$urandom_range(0, 6)];
      apb_access(w, 16'($urandom), $urandom, s, 3'($urandom),
                 $urandom_range(0, 3), ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_bridge_apb2ahb_master.md
Name: peripheral_bridge_apb2ahb_master

Overview:
- Same-clock APB4 slave to AHB3-Lite master bridge.
- Lets an APB-side initiator (e.g. an MPI/UART DMA or a debug unit sitting on APB) issue single AHB transfers into system memory.
- Each APB access becomes exactly one AHB SINGLE/NONSEQ transfer, and the APB access completes only after the AHB data phase ends.
- No buffering: one outstanding transfer at a time.

Parameters:
- HADDR_SIZE, 32, AHB address width.
- HDATA_SIZE, 32, AHB/APB data width; only 32 is supported.
- PADDR_SIZE, 16, APB address width; must be <= HADDR_SIZE.
- HADDR_BASE, 32'h0000_0000, value ORed onto the zero-extended PADDR to form HADDR.

Ports:
- HCLK  in  1  single clock for both sides.
- HRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB direction.
- PADDR  in  PADDR_SIZE  APB byte address.
- PWDATA  in  32  APB write data.
- PSTRB  in  4  APB write strobes.
- PPROT  in  3  APB protection.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB transfer complete.
- PSLVERR  out  1  APB error.
- HADDR  out  HADDR_SIZE  AHB address.
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  AHB size.
- HBURST  out  3  AHB burst, tied to SINGLE.
- HPROT  out  4  AHB protection.
- HTRANS  out  2  AHB transfer type.
- HMASTLOCK  out  1  AHB lock, tied to 0.
- HREADY  in  1  AHB bus ready.
- HRESP  in  1  AHB response.

Behaviour:
- Clock and reset: one clock, HCLK. Reset is HRESET, synchronous and active-high.
- Reset values: state IDLE; HTRANS=IDLE(00); HWRITE=0; HADDR=0; HSIZE=010; HPROT=0011; HWDATA=0; PREADY=0; PSLVERR=0; PRDATA=0.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE, trigger: PSEL&PENABLE registers address, control and write data.
  - HADDR = HADDR_BASE | {PADDR[PADDR_SIZE-1:2], lo}.
  - HSIZE and lo come from the strobe decode below.
  - HPROT = {1'b0, 1'b0, PPROT[0], ~PPROT[2]}.
- IDLE transitions: on trigger with a legal strobe -> ADDR; on an illegal write strobe -> DONE with the error flag set, and no AHB transfer is issued.
- Strobe decode, writes:
  - 1111 -> word, lo=00.
  - 0011 -> half, lo=00; 1100 -> half, lo=10.
  - one-hot bit n -> byte, lo=n.
  - anything else is illegal.
- Strobe decode, reads: PSTRB is ignored; word access, lo=00.
- ADDR: HTRANS=NONSEQ, held until HREADY=1; then -> DATA, where HTRANS returns to IDLE and HWDATA is driven.
- DATA:
  - HREADY=1 & HRESP=0: capture HRDATA (reads) -> DONE, error=0.
  - HREADY=0 & HRESP=1: first error cycle; stay in DATA.
  - HREADY=1 & HRESP=1: -> DONE, error=1.
  - HREADY=0 & HRESP=0: wait.
- DONE: PREADY=1 for exactly one cycle, PSLVERR=error, PRDATA=captured data (0 on error or write) -> IDLE. PREADY is 0 in every other state.
- Re-trigger protection: in IDLE the cycle after DONE, PENABLE is low per APB protocol, so the same access cannot trigger twice.
- Latency, zero-wait AHB: access phase seen at cycle 0, NONSEQ driven cycle 1, data phase cycle 2, PREADY=1 cycle 3.
- APB inputs are sampled only in IDLE. Changes of PSEL/PADDR during a transfer are ignored (APB rules forbid them).
- Reset mid-transfer: next edge forces IDLE and HTRANS=IDLE. The outstanding AHB transfer is abandoned (system-wide reset).

Optional Feature:
- Macro: PERIPHERAL_BRIDGE_APB2AHB_ERRCAPTURE_EN.
- When defined, adds outputs err_valid_o (1 bit) and err_addr_o (HADDR_SIZE bits).
  - Any PSLVERR=1 completion sets err_valid_o and loads err_addr_o with the failing HADDR. For an illegal strobe, that is the HADDR that would have been used.
  - err_clr_i (in, 1) clears err_valid_o; a set in the same cycle wins.
  - Both outputs reset to 0.
- When undefined, these ports and the logic are absent.

Decomposition:
- Package peripheral_bridge_apb2ahb_pkg:
  - state enum;
  - HTRANS_IDLE/NONSEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HBURST_SINGLE;
  - HRESP_OKAY/ERROR.
- Combinational sub-module peripheral_bridge_strb2size: inputs PSTRB, PWRITE; outputs hsize, lo[1:0], illegal.

Test Plan:
- Read PADDR=16'h0040, zero-wait slave returns HRDATA=32'hDEADBEEF -> HADDR=32'h40, HSIZE=010, HWRITE=0, PREADY on cycle 3, PRDATA=DEADBEEF, PSLVERR=0.
- Write PADDR=16'h0013, PSTRB=1000, PWDATA=32'h5A000000 -> HADDR=32'h13, HSIZE=000, HWDATA=5A000000 during the data phase, single NONSEQ cycle.
- Write with PSTRB=0110 -> no NONSEQ issued, PREADY=1 and PSLVERR=1 one cycle after the access phase. err_valid_o=1 if the macro is defined.
- Slave inserts 3 HREADY=0 wait states then OKAY -> PREADY delayed by exactly 3 cycles, stays 0 until then.
- Two-cycle ERROR response on a read -> FSM stays in DATA through the first cycle, PREADY=1 with PSLVERR=1 and PRDATA=0.
- HRESET asserted in DATA with HREADY=0 -> next cycle HTRANS=00 and PREADY=0. A fresh access afterwards completes normally.
